// File: rtl/inv_mode_ctrl.sv
// -----------------------------------------------------------------------------
// inv_mode_ctrl
//
// Frame-synchronous controller for the pixel-inversion datapath.
//  - Debounces the raw mode switches and commits a new invert mode only on a
//    vertical-sync rising edge, so one frame is never split between two modes.
//  - Produces the per-pixel invert select from the block-darkness decision.
//  - Sequences the upstream hot-plug-detect with a settle delay after the
//    downstream HPD rises; a downstream drop releases it immediately.
//
// Parameters:
//   DEB_CYCLES  clocks a switch value must be stable before it is accepted
//   HPD_DELAY   clocks downstream HPD must stay high before upstream HPD rises
//
// Ports (all in the clk_i domain unless noted):
//   clk_i        input pixel clock
//   rst_i        synchronous reset, active-high
//   sw_i         raw mode switches (asynchronous)
//   hpd_force_i  force upstream HPD high (asynchronous)
//   vs_i         input vertical sync, active-high
//   blk_x_i      current-block "dark" decision
//   vout_hpd_i   downstream HPD (asynchronous)
//   px_inv_o     invert current pixel (combinational from blk_x_i)
//   mode_o       committed mode
//   pending_o    stable switch value differs from committed mode
//   vin_hpd_o    upstream HPD
//
// Optional build macro INV_MODE_CTRL_FRAME_CNT_EN adds:
//   frame_cnt_o     frame counter, wraps at 16 bits
//   mode_changes_o  count of frames where the committed mode changed (saturates)
// -----------------------------------------------------------------------------
module inv_mode_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int HPD_DELAY  = 16777216
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sw_i,
    input  logic        hpd_force_i,
    input  logic        vs_i,
    input  logic        blk_x_i,
    input  logic        vout_hpd_i,
    output logic        px_inv_o,
    output logic [1:0]  mode_o,
    output logic        pending_o,
    output logic        vin_hpd_o
`ifdef INV_MODE_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [7:0]  mode_changes_o
`endif
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int HPD_W = $clog2(HPD_DELAY + 1);

    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [HPD_W-1:0] HPD_LAST = HPD_W'(HPD_DELAY - 1);

    typedef enum logic [1:0] {
        HPD_DOWN = 2'd0,
        HPD_WAIT = 2'd1,
        HPD_UP   = 2'd2
    } hpd_state_t;

    // Synchroniser stages
    logic [1:0]       sw_meta_r;
    logic [1:0]       sw_sync_r;
    logic             force_meta_r;
    logic             force_sync_r;
    logic             vout_meta_r;
    logic             vout_sync_r;

    // Debounce state
    logic [1:0]       cand_r;
    logic [1:0]       stable_r;
    logic [DEB_W-1:0] deb_cnt_r;

    // Frame / mode state
    logic             vs_q_r;
    logic             frame_start_s;
    logic [1:0]       mode_r;
    logic             pending_r;
    logic             px_inv_s;

    // HPD sequencer
    hpd_state_t       hpd_state_r;
    hpd_state_t       hpd_next_s;
    logic [HPD_W-1:0] hpd_cnt_r;
    logic [HPD_W-1:0] hpd_cnt_next_s;
    logic             vin_hpd_r;

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_meta_r    <= 2'b00;
            sw_sync_r    <= 2'b00;
            force_meta_r <= 1'b0;
            force_sync_r <= 1'b0;
            vout_meta_r  <= 1'b0;
            vout_sync_r  <= 1'b0;
        end else begin
            sw_meta_r    <= sw_i;
            sw_sync_r    <= sw_meta_r;
            force_meta_r <= hpd_force_i;
            force_sync_r <= force_meta_r;
            vout_meta_r  <= vout_hpd_i;
            vout_sync_r  <= vout_meta_r;
        end
    end

    // Switch debounce: any change restarts the count; the stable value is
    // taken from the registered count so it lands one clock after saturation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_r    <= 2'b00;
            stable_r  <= 2'b00;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else begin
            if (sw_sync_r != cand_r) begin
                cand_r    <= sw_sync_r;
                deb_cnt_r <= {DEB_W{1'b0}};
            end else if (deb_cnt_r != DEB_MAX) begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
            if (deb_cnt_r == DEB_MAX) begin
                stable_r <= cand_r;
            end
        end
    end

    // vs_i is already in this clock domain, so only edge detection is needed
    assign frame_start_s = vs_i & ~vs_q_r;

    // Mode commit at frame start; stable_r is the pre-edge value, so a switch
    // settling in the same cycle waits for the next frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q_r    <= 1'b0;
            mode_r    <= 2'b00;
            pending_r <= 1'b0;
        end else begin
            vs_q_r    <= vs_i;
            pending_r <= (stable_r != mode_r);
            if (frame_start_s) begin
                mode_r <= stable_r;
            end
        end
    end

    // Per-pixel invert select; must be zero-latency from blk_x_i
    always_comb begin
        px_inv_s = blk_x_i;
        case (mode_r)
            2'b00:   px_inv_s = blk_x_i;
            2'b01:   px_inv_s = 1'b0;
            2'b10:   px_inv_s = 1'b1;
            2'b11:   px_inv_s = ~blk_x_i;
            default: px_inv_s = blk_x_i;
        endcase
    end

    // HPD sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hpd_state_r <= HPD_DOWN;
            hpd_cnt_r   <= {HPD_W{1'b0}};
            vin_hpd_r   <= 1'b0;
        end else begin
            hpd_state_r <= hpd_next_s;
            hpd_cnt_r   <= hpd_cnt_next_s;
            vin_hpd_r   <= (hpd_next_s == HPD_UP) | force_sync_r;
        end
    end

    // HPD sequencer next state: settle delay on rise, immediate release on drop
    always_comb begin
        hpd_next_s     = hpd_state_r;
        hpd_cnt_next_s = hpd_cnt_r;
        case (hpd_state_r)
            HPD_DOWN: begin
                hpd_cnt_next_s = {HPD_W{1'b0}};
                if (vout_sync_r) begin
                    hpd_next_s = HPD_WAIT;
                end else begin
                    hpd_next_s = HPD_DOWN;
                end
            end
            HPD_WAIT: begin
                if (!vout_sync_r) begin
                    hpd_next_s     = HPD_DOWN;
                    hpd_cnt_next_s = {HPD_W{1'b0}};
                end else if (hpd_cnt_r == HPD_LAST) begin
                    hpd_next_s = HPD_UP;
                end else begin
                    hpd_cnt_next_s = hpd_cnt_r + HPD_W'(1);
                end
            end
            HPD_UP: begin
                if (!vout_sync_r) begin
                    hpd_next_s = HPD_DOWN;
                end else begin
                    hpd_next_s = HPD_UP;
                end
            end
            default: begin
                hpd_next_s     = HPD_DOWN;
                hpd_cnt_next_s = {HPD_W{1'b0}};
            end
        endcase
    end

`ifdef INV_MODE_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;
    logic [7:0]  mode_chg_r;

    // Frame statistics: wrapping frame count, saturating mode-change count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_r <= 16'h0000;
            mode_chg_r  <= 8'h00;
        end else if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            if ((stable_r != mode_r) && (mode_chg_r != 8'hFF)) begin
                mode_chg_r <= mode_chg_r + 8'd1;
            end
        end
    end

    assign frame_cnt_o    = frame_cnt_r;
    assign mode_changes_o = mode_chg_r;
`endif

    assign px_inv_o  = px_inv_s;
    assign mode_o    = mode_r;
    assign pending_o = pending_r;
    assign vin_hpd_o = vin_hpd_r;

endmodule
